// File: rtl/gaussian_dsm_writer.sv
// gaussian_dsm_writer: queues AFU events and posts each one as a 64B status
// line into the host DSM ring over CCI-P channel 1. Only one write is kept
// outstanding, so the host sees sequence numbers in strictly increasing ring
// order. Optional write-response timeout: define GAUSSIAN_DSM_TIMEOUT_EN.
module gaussian_dsm_writer #(
    parameter int EVT_DEPTH      = 8,
    parameter int DSM_LINES      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [41:0]  dsm_base,
    input  logic         evt_valid,
    output logic         evt_ready,
    input  logic [31:0]  evt_code,
    output logic         c1tx_valid,
    output logic [41:0]  c1tx_addr,
    output logic [15:0]  c1tx_mdata,
    output logic [511:0] c1tx_data,
    input  logic         c1tx_almfull,
    input  logic         c1rx_wrrsp_valid,
    input  logic [15:0]  c1rx_mdata,
    output logic         busy,
    output logic         err_timeout
);

    localparam int AW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int IW = (DSM_LINES > 1) ? $clog2(DSM_LINES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [31:0]     r_mem [EVT_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic [31:0]     r_seq;
    logic [IW-1:0]   r_idx;
    logic [63:0]     r_cycle;

    logic            r_c1tx_valid;
    logic [41:0]     r_c1tx_addr;
    logic [15:0]     r_c1tx_mdata;
    logic [511:0]    r_c1tx_data;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_ack;
    logic            w_timeout;
    logic            w_advance;
    logic [31:0]     w_seq_inc;

    assign w_full    = (r_count == CW'(EVT_DEPTH));
    assign w_empty   = (r_count == {CW{1'b0}});
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign evt_ready = !w_full || w_pop;
    assign w_push    = evt_valid && evt_ready;
    assign w_ack     = (r_state == S_WAIT) && c1rx_wrrsp_valid
                       && (c1rx_mdata == r_seq[15:0]);
    assign w_seq_inc = r_seq + 32'd1;
    assign busy      = !w_empty || (r_state != S_IDLE);

    assign c1tx_valid = r_c1tx_valid;
    assign c1tx_addr  = r_c1tx_addr;
    assign c1tx_mdata = r_c1tx_mdata;
    assign c1tx_data  = r_c1tx_data;

`ifdef GAUSSIAN_DSM_TIMEOUT_EN
    logic [31:0] r_to_cnt;
    logic        r_err_timeout;

    assign w_timeout   = (r_state == S_WAIT) && !w_ack
                         && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign err_timeout = r_err_timeout;

    // Count cycles spent waiting for the write response; sticky error on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt      <= 32'd0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end else begin
                r_to_cnt <= 32'd0;
            end
            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end else begin
                r_err_timeout <= r_err_timeout;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a zero base keeps events parked in the FIFO.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && (dsm_base != 42'd0)) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (!c1tx_almfull) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (w_advance) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: issue a write (and pop) once, advance on ack or timeout.
    always_comb begin
        w_pop     = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            S_ISSUE: begin
                w_pop = !c1tx_almfull;
            end
            S_WAIT: begin
                w_advance = w_ack || w_timeout;
            end
            default: begin
                w_pop     = 1'b0;
                w_advance = 1'b0;
            end
        endcase
    end

    // Event FIFO storage; contents need no reset since occupancy is tracked.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= evt_code;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Event FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write request datapath, sequence/ring index bookkeeping, cycle stamp.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle      <= 64'd0;
            r_seq        <= 32'd1;
            r_idx        <= {IW{1'b0}};
            r_c1tx_valid <= 1'b0;
            r_c1tx_addr  <= 42'd0;
            r_c1tx_mdata <= 16'd0;
            r_c1tx_data  <= 512'd0;
        end else begin
            r_cycle      <= r_cycle + 64'd1;
            r_c1tx_valid <= w_pop;
            if (w_pop) begin
                r_c1tx_addr  <= dsm_base + 42'(r_idx);
                r_c1tx_mdata <= r_seq[15:0];
                r_c1tx_data  <= {384'd0, r_cycle, r_seq, r_mem[r_rd_ptr]};
            end else begin
                r_c1tx_addr  <= r_c1tx_addr;
                r_c1tx_mdata <= r_c1tx_mdata;
                r_c1tx_data  <= r_c1tx_data;
            end
            if (w_advance) begin
                // Sequence 0 is reserved so the host can treat it as "empty line".
                r_seq <= (w_seq_inc == 32'd0) ? 32'd1 : w_seq_inc;
                r_idx <= (DSM_LINES == 1) ? {IW{1'b0}} : (r_idx + IW'(1));
            end else begin
                r_seq <= r_seq;
                r_idx <= r_idx;
            end
        end
    end

endmodule
